// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM (core load/store port and aux loader/debug port).
// Define ARB_ROUND_ROBIN_EN for alternating grants on simultaneous requests; default is fixed core priority.
module dmem_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          CLOCK,
   input  logic          RST_n,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_ack,
   output logic [DW-1:0] core_rdata,
   output logic          core_stall,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [DW-1:0] aux_wdata,
   output logic          aux_ack,
   output logic [DW-1:0] aux_rdata,
   output logic          ram_ena_wr,
   output logic          ram_ena_rd,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   output logic          owner
);

   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("dmem_arbiter: RD_LAT=%0d is outside the legal range 1..4", RD_LAT);
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state_q;
   logic [2:0]    cnt_q;
   logic          we_q;
   logic          owner_q;
   logic          ram_ena_wr_q;
   logic          ram_ena_rd_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_wdata_q;
   logic          core_ack_q;
   logic          aux_ack_q;
   logic [DW-1:0] core_rdata_q;
   logic [DW-1:0] aux_rdata_q;

   logic          grant_aux_d;
   logic          sel_we_d;
   logic [AW-1:0] sel_addr_d;
   logic [DW-1:0] sel_wdata_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic          last_grant_q;

   // Only a genuine tie consults the history; a lone requester always wins.
   always_comb begin
      grant_aux_d = 1'b0;
      if (aux_req && !core_req) begin
         grant_aux_d = 1'b1;
      end else if (aux_req && core_req) begin
         grant_aux_d = ~last_grant_q;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RST_n) begin
         last_grant_q <= 1'b1;
      end else if (state_q == S_IDLE && (core_req || aux_req)) begin
         last_grant_q <= grant_aux_d;
      end
   end
`else
   always_comb begin
      grant_aux_d = aux_req & ~core_req;
   end
`endif

   always_comb begin
      sel_we_d    = grant_aux_d ? aux_we    : core_we;
      sel_addr_d  = grant_aux_d ? aux_addr  : core_addr;
      sel_wdata_d = grant_aux_d ? aux_wdata : core_wdata;
   end

   always_ff @(posedge CLOCK) begin
      if (!RST_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 3'd0;
         we_q         <= 1'b0;
         owner_q      <= 1'b0;
         ram_ena_wr_q <= 1'b0;
         ram_ena_rd_q <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         core_ack_q   <= 1'b0;
         aux_ack_q    <= 1'b0;
         core_rdata_q <= '0;
         aux_rdata_q  <= '0;
      end else begin
         ram_ena_wr_q <= 1'b0;
         ram_ena_rd_q <= 1'b0;
         core_ack_q   <= 1'b0;
         aux_ack_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (core_req || aux_req) begin
                  owner_q      <= grant_aux_d;
                  we_q         <= sel_we_d;
                  ram_addr_q   <= sel_addr_d;
                  ram_wdata_q  <= sel_wdata_d;
                  ram_ena_wr_q <= sel_we_d;
                  ram_ena_rd_q <= ~sel_we_d;
                  state_q      <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (we_q) begin
                  core_ack_q <= ~owner_q;
                  aux_ack_q  <= owner_q;
                  state_q    <= S_DONE;
               end else begin
                  cnt_q   <= 3'(RD_LAT);
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Count of 1 marks the cycle in which ram_rdata is valid.
               if (cnt_q == 3'd1) begin
                  if (owner_q) begin
                     aux_rdata_q <= ram_rdata;
                  end else begin
                     core_rdata_q <= ram_rdata;
                  end
                  core_ack_q <= ~owner_q;
                  aux_ack_q  <= owner_q;
                  cnt_q      <= 3'd0;
                  state_q    <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign core_ack   = core_ack_q;
   assign aux_ack    = aux_ack_q;
   assign core_rdata = core_rdata_q;
   assign aux_rdata  = aux_rdata_q;
   assign core_stall = core_req & ~core_ack_q;
   assign ram_ena_wr = ram_ena_wr_q;
   assign ram_ena_rd = ram_ena_rd_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign owner      = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level timing model predicts strobes, acks and read data.
// Define ARB_ROUND_ROBIN_EN here and in the RTL build to check the alternating-grant variant.
module tb_dmem_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic          CLOCK = 1'b0;
   logic          RST_n = 1'b0;
   logic          core_req = 1'b0, core_we = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic          aux_req = 1'b0, aux_we = 1'b0;
   logic [AW-1:0] aux_addr = '0;
   logic [DW-1:0] aux_wdata = '0;
   logic          core_ack, aux_ack, core_stall, ram_ena_wr, ram_ena_rd, owner;
   logic [DW-1:0] core_rdata, aux_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;

   always #5 CLOCK = ~CLOCK;

   dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
      .CLOCK(CLOCK), .RST_n(RST_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata), .core_stall(core_stall),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_ack(aux_ack), .aux_rdata(aux_rdata),
      .ram_ena_wr(ram_ena_wr), .ram_ena_rd(ram_ena_rd), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
   );

   function automatic logic [DW-1:0] init_word(input int idx);
      return 32'h1000_0000 + 32'(idx) * 32'h0001_0101;
   endfunction

   // RAM with LAT-cycle read pipeline; junk is returned whenever no read was issued.
   bit [DW-1:0]   ram_mem [16];
   bit [15:0]     ram_wr_seen;
   logic [DW-1:0] rd_pipe [4];
   always @(posedge CLOCK) begin
      if (ram_ena_wr) begin
         ram_mem[ram_addr[5:2]]     <= ram_wdata;
         ram_wr_seen[ram_addr[5:2]] <= 1'b1;
      end
      if (ram_ena_rd)
         rd_pipe[0] <= ram_wr_seen[ram_addr[5:2]] ? ram_mem[ram_addr[5:2]] : init_word(int'(ram_addr[5:2]));
      else
         rd_pipe[0] <= DW'($urandom);
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[LAT-1];

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   req_t          core_q[$], aux_q[$];
   req_t          core_cur, aux_cur, m_req;
   bit            core_pend, aux_pend, m_win, m_last, exp_owner;
   logic [DW-1:0] m_mem [16];
   logic [DW-1:0] m_rdata, exp_core_rd, exp_aux_rd;
   int            cyc, idle_cyc, acc_cyc, ack_cyc;
   int            errors, checks;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic req_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      req_t r;
      r.we = we; r.addr = addr; r.wdata = wdata;
      return r;
   endfunction

   function automatic req_t rand_req();
      return mk(1'($urandom_range(1)), AW'($urandom), DW'($urandom));
   endfunction

   // One clock cycle: check the cycle's outputs against the model, then drive and plan ahead.
   task automatic step(input logic rst_n_val, input int pct);
      bit exp_wr, exp_rd, exp_cack, exp_aack;
      @(posedge CLOCK);
      #1;
      cyc++;
      if (!RST_n) begin
         acc_cyc = -1; ack_cyc = -1; idle_cyc = cyc;
         exp_core_rd = '0; exp_aux_rd = '0; exp_owner = 1'b0; m_last = 1'b1;
      end
      exp_wr   = (cyc == acc_cyc) && m_req.we;
      exp_rd   = (cyc == acc_cyc) && !m_req.we;
      exp_cack = (cyc == ack_cyc) && !m_win;
      exp_aack = (cyc == ack_cyc) && m_win;
      if (cyc == acc_cyc) exp_owner = m_win;
      if (cyc == ack_cyc && !m_req.we) begin
         if (m_win) exp_aux_rd = m_rdata;
         else       exp_core_rd = m_rdata;
      end
      check("strobes", 64'({ram_ena_wr, ram_ena_rd}), 64'({exp_wr, exp_rd}));
      check("acks", 64'({core_ack, aux_ack}), 64'({exp_cack, exp_aack}));
      check("owner", 64'(owner), 64'(exp_owner));
      check("core_rdata", 64'(core_rdata), 64'(exp_core_rd));
      check("aux_rdata", 64'(aux_rdata), 64'(exp_aux_rd));
      if (cyc == acc_cyc) begin
         check("ram_addr", 64'(ram_addr), 64'(m_req.addr));
         if (m_req.we) check("ram_wdata", 64'(ram_wdata), 64'(m_req.wdata));
      end
      if (cyc == ack_cyc) begin
         $display("txn cyc=%0d port=%s we=%0d addr=%h data=%h", cyc, m_win ? "aux" : "core",
                  m_req.we, m_req.addr, m_req.we ? m_req.wdata : m_rdata);
         if (m_win) aux_pend = 1'b0;
         else       core_pend = 1'b0;
      end

      RST_n = rst_n_val;
      if (!core_pend) begin
         if (core_q.size() > 0) begin core_cur = core_q.pop_front(); core_pend = 1'b1; end
         else if (int'($urandom_range(99)) < pct) begin core_cur = rand_req(); core_pend = 1'b1; end
      end
      if (!aux_pend) begin
         if (aux_q.size() > 0) begin aux_cur = aux_q.pop_front(); aux_pend = 1'b1; end
         else if (int'($urandom_range(99)) < pct) begin aux_cur = rand_req(); aux_pend = 1'b1; end
      end
      core_req = core_pend; core_we = core_cur.we; core_addr = core_cur.addr; core_wdata = core_cur.wdata;
      aux_req  = aux_pend;  aux_we  = aux_cur.we;  aux_addr  = aux_cur.addr;  aux_wdata  = aux_cur.wdata;
      #1;
      check("core_stall", 64'(core_stall), 64'(core_req & ~exp_cack));

      // Arbiter is free in idle_cyc: the winner gets ACCESS next cycle, ack after the access latency.
      if (RST_n && cyc == idle_cyc) begin
         if (core_req || aux_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            m_win = (core_req && aux_req) ? !m_last : aux_req;
`else
            m_win = !core_req;
`endif
            m_last   = m_win;
            m_req    = m_win ? aux_cur : core_cur;
            acc_cyc  = cyc + 1;
            ack_cyc  = m_req.we ? cyc + 2 : cyc + 2 + LAT;
            idle_cyc = ack_cyc + 1;
            if (m_req.we) m_mem[m_req.addr[5:2]] = m_req.wdata;
            else          m_rdata = m_mem[m_req.addr[5:2]];
         end else begin
            idle_cyc = cyc + 1;
         end
      end
   endtask

   initial begin
      bit found;
      errors = 0; checks = 0; cyc = 0;
      acc_cyc = -1; ack_cyc = -1; idle_cyc = -1;
      m_last = 1'b1; exp_owner = 1'b0; exp_core_rd = '0; exp_aux_rd = '0;
      core_pend = 1'b0; aux_pend = 1'b0;
      core_cur = '0; aux_cur = '0; m_req = '0; m_win = 1'b0; m_rdata = '0;
      for (int i = 0; i < 16; i++) m_mem[i] = init_word(i);

      // Both masters request writes while reset is held, then contend on release.
      core_q.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
      aux_q.push_back(mk(1'b1, 32'h20, 32'h12345678));
      step(1'b0, 0);
      step(1'b0, 0);
      for (int i = 0; i < 12; i++) step(1'b1, 0);

      aux_q.push_back(mk(1'b0, 32'h20, 32'h0));
      for (int i = 0; i < 10; i++) step(1'b1, 0);

      // Back-to-back core reads with req held through the first ack.
      core_q.push_back(mk(1'b0, 32'h0, 32'h0));
      core_q.push_back(mk(1'b0, 32'h4, 32'h0));
      for (int i = 0; i < 16; i++) step(1'b1, 0);

      // Reset while a core read is waiting for RAM data.
      core_q.push_back(mk(1'b0, 32'h8, 32'h0));
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 0);
         found = (cyc == acc_cyc) && !m_win && !m_req.we;
      end
      check("reach_access", 64'(found), 64'(1));
      step(1'b0, 0);
      step(1'b0, 0);
      for (int i = 0; i < 14; i++) step(1'b1, 0);

      // Both masters keep requesting: grant order depends on the arbitration mode.
      for (int i = 0; i < 3; i++) core_q.push_back(mk(1'b1, 32'h40 + 32'(i * 4), DW'($urandom)));
      for (int i = 0; i < 2; i++) aux_q.push_back(mk(1'b1, 32'h80 + 32'(i * 4), DW'($urandom)));
      for (int i = 0; i < 24; i++) step(1'b1, 0);

      for (int i = 0; i < 1500; i++) step(1'b1, 40);
      for (int i = 0; i < 30; i++) step(1'b1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
